pio_rsp: RTL and testbench

- Return path of the PIO request demultiplexer: merges per-channel PIO completion streams into one completion stream toward the PCIe completer interface.
- Channels: 5 UAR, 4 P2P MEM, 3 P2P CFG, 2 HCA MSI-X table, 1 Ethernet, 0 HCR CFG.
- Round-robin arbitration, packet-locked grant and a 2-entry output skid buffer give full throughput with a registered output.

---
 rtl/pio_rsp_pkg.sv | 32 +++
 rtl/pio_rsp_if.sv | 33 +++
 rtl/pio_rsp_skid.sv | 59 +++++
 rtl/pio_rsp.sv | 108 ++++++++++
 tb/tb_pio_rsp.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pio_rsp_pkg.sv
// Shared widths, channel indices and beat type for the PIO completion return path.
package pio_rsp_pkg;

   // head = {is_wr[39], bar_id[38:36], addr[35:24], cc_head[23:0]}
   localparam int PIO_DATA_W = 32;
   localparam int PIO_HEAD_W = 40;

   localparam int PIO_CHNL_HCR  = 0;
   localparam int PIO_CHNL_ETH  = 1;
   localparam int PIO_CHNL_MSIX = 2;
   localparam int PIO_CHNL_CFG  = 3;
   localparam int PIO_CHNL_MEM  = 4;
   localparam int PIO_CHNL_UAR  = 5;

   localparam int PIO_RSP_SIGNAL_W = 40;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } rsp_state_t;

   typedef struct packed {
      logic [PIO_DATA_W-1:0] data;
      logic [PIO_HEAD_W-1:0] head;
      logic                  last;
   } rsp_beat_t;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/pio_rsp_if.sv
// Per-channel completion inputs and the merged completion output of pio_rsp.
interface pio_rsp_if #(
   parameter int CHANNEL_NUM = 6
) ();
   import pio_rsp_pkg::*;

   logic [CHANNEL_NUM*PIO_DATA_W-1:0] s_axis_rsp_data;
   logic [CHANNEL_NUM*PIO_HEAD_W-1:0] s_axis_rsp_head;
   logic [CHANNEL_NUM-1:0]            s_axis_rsp_last;
   logic [CHANNEL_NUM-1:0]            s_axis_rsp_valid;
   logic [CHANNEL_NUM-1:0]            s_axis_rsp_ready;

   logic [PIO_DATA_W-1:0]             m_axis_rsp_tdata;
   logic [PIO_HEAD_W-1:0]             m_axis_rsp_thead;
   logic                              m_axis_rsp_tlast;
   logic                              m_axis_rsp_tvalid;
   logic                              m_axis_rsp_tready;

   modport slave (
      input  s_axis_rsp_data, s_axis_rsp_head, s_axis_rsp_last, s_axis_rsp_valid,
      output s_axis_rsp_ready,
      output m_axis_rsp_tdata, m_axis_rsp_thead, m_axis_rsp_tlast, m_axis_rsp_tvalid,
      input  m_axis_rsp_tready
   );

   modport master (
      output s_axis_rsp_data, s_axis_rsp_head, s_axis_rsp_last, s_axis_rsp_valid,
      input  s_axis_rsp_ready,
      input  m_axis_rsp_tdata, m_axis_rsp_thead, m_axis_rsp_tlast, m_axis_rsp_tvalid,
      output m_axis_rsp_tready
   );

endinterface

// File: rtl/pio_rsp_skid.sv
// Two-entry register FIFO; ent0 is always the head entry and drives the output directly.
module pio_rsp_skid
   import pio_rsp_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  rsp_beat_t in_beat,
   input  logic      in_valid,
   output logic      in_ready,
   output rsp_beat_t out_beat,
   output logic      out_valid,
   input  logic      out_ready
);

   logic [1:0] count_q, count_d;
   rsp_beat_t  ent0_q, ent0_d, ent1_q, ent1_d;
   logic       push, pop;

   // in_ready only looks at the registered count, never at out_ready
   assign in_ready  = (count_q < 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign out_beat  = ent0_q;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      count_d = count_q;
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) ent0_d = in_beat;
            else                 ent1_d = in_beat;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            ent0_d  = ent1_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd1) begin
               ent0_d = in_beat;
            end else begin
               ent0_d = ent1_q;
               ent1_d = in_beat;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= 2'd0;
      else     count_q <= count_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
   end

endmodule

// File: rtl/pio_rsp.sv
// Merges per-channel PIO completion streams into one, round-robin with packet lock.
// state | meaning
// IDLE  | between packets, round-robin pick from rr_ptr upward
// LOCK  | mid-packet, only lock_id may transfer
module pio_rsp
   import pio_rsp_pkg::*;
#(
   parameter int CHANNEL_NUM = 6
) (
   input  logic        clk,
   input  logic        rst,
   pio_rsp_if.slave    rsp_if,
   output logic [31:0] rsp_pkt_cnt
);

   localparam int PTR_W = $clog2(CHANNEL_NUM);

   rsp_state_t       state_q, state_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d, lock_id_q, lock_id_d;
   logic [31:0]      pkt_cnt_q, pkt_cnt_d;
   logic [PTR_W-1:0] pick, sel;
   logic             pick_found, sel_ok, in_valid, in_ready, accept, out_valid;
   rsp_beat_t        in_beat, out_beat;

   always_comb begin : arb
      int               pos;
      logic [PTR_W-1:0] idx;
      pick_found = 1'b0;
      pick       = '0;
      pos        = 0;
      idx        = '0;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
         pos = int'(rr_ptr_q) + i;
         if (pos >= CHANNEL_NUM) pos = pos - CHANNEL_NUM;
         idx = PTR_W'(pos);
         if (!pick_found && rsp_if.s_axis_rsp_valid[idx]) begin
            pick_found = 1'b1;
            pick       = idx;
         end
      end
   end

   always_comb begin
      sel           = (state_q == LOCK) ? lock_id_q : pick;
      sel_ok        = (state_q == LOCK) || pick_found;
      in_beat.data  = rsp_if.s_axis_rsp_data[int'(sel)*PIO_DATA_W +: PIO_DATA_W];
      in_beat.head  = rsp_if.s_axis_rsp_head[int'(sel)*PIO_HEAD_W +: PIO_HEAD_W];
      in_beat.last  = rsp_if.s_axis_rsp_last[sel];
      in_valid      = sel_ok && !rst && rsp_if.s_axis_rsp_valid[sel];
      accept        = in_valid && in_ready;
      rsp_if.s_axis_rsp_ready = '0;
      if (sel_ok && !rst) rsp_if.s_axis_rsp_ready[sel] = in_ready;
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      lock_id_d = lock_id_q;
      pkt_cnt_d = pkt_cnt_q;
      if (accept) begin
         if (state_q == IDLE) begin
            if (!in_beat.last) begin
               state_d   = LOCK;
               lock_id_d = pick;
            end else begin
               rr_ptr_d = PTR_W'(wrap_inc(int'(pick), CHANNEL_NUM));
            end
         end else if (in_beat.last) begin
            state_d  = IDLE;
            rr_ptr_d = PTR_W'(wrap_inc(int'(lock_id_q), CHANNEL_NUM));
         end
      end
      if (out_valid && rsp_if.m_axis_rsp_tready && out_beat.last)
         pkt_cnt_d = pkt_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         lock_id_q <= '0;
         pkt_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         lock_id_q <= lock_id_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   pio_rsp_skid u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_beat   (in_beat),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_beat  (out_beat),
      .out_valid (out_valid),
      .out_ready (rsp_if.m_axis_rsp_tready)
   );

   assign rsp_if.m_axis_rsp_tdata  = out_beat.data;
   assign rsp_if.m_axis_rsp_thead  = out_beat.head;
   assign rsp_if.m_axis_rsp_tlast  = out_beat.last;
   assign rsp_if.m_axis_rsp_tvalid = out_valid;
   assign rsp_pkt_cnt              = pkt_cnt_q;

endmodule

// File: tb/tb_pio_rsp.sv
// Bench for pio_rsp: per-channel packet sources, output capture and directed checks.
module tb_pio_rsp;
   import pio_rsp_pkg::*;

   localparam int CH = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rsp_pkt_cnt;

   always #5 clk = ~clk;

   pio_rsp_if #(.CHANNEL_NUM(CH)) bus ();

   pio_rsp #(.CHANNEL_NUM(CH)) dut (
      .clk         (clk),
      .rst         (rst),
      .rsp_if      (bus),
      .rsp_pkt_cnt (rsp_pkt_cnt)
   );

   typedef struct {
      logic [PIO_DATA_W-1:0] data;
      logic [PIO_HEAD_W-1:0] head;
      logic                  last;
      int                    cyc;
   } out_t;

   typedef struct {
      logic [CH-1:0] pend;
      int            n;
      logic [23:0]   order;
      logic [2:0]    rr_after;
   } vec_t;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          rr_bad = 0;
   int          pk_len[CH][$];
   int          pk_seq[CH][$];
   int          beat_i[CH];
   int          bub[CH];
   int          seq_next[CH];
   int          acc_cnt[CH];
   int          acc_cyc[$];
   out_t        out_q[$];
   logic [CH-1:0] hs_v;
   logic        tready_want;
   logic        rst_want;
   vec_t        vt[7];

   function automatic logic [PIO_DATA_W-1:0] mk_data(input int ch, input int seq, input int beat);
      return {4'hA, 4'(ch), 8'(seq), 16'(beat)};
   endfunction

   function automatic logic [PIO_HEAD_W-1:0] mk_head(input int ch, input int seq);
      return {8'(ch * 17 + 3), 32'(seq * 7 + ch * 1000 + 1)};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_beat(input string nm, input int idx, input int ch, input int seq,
                           input int beat, input logic last);
      logic [127:0] act, exp;
      exp = {55'b0, mk_data(ch, seq, beat), mk_head(ch, seq), last};
      if (idx < out_q.size()) act = {55'b0, out_q[idx].data, out_q[idx].head, out_q[idx].last};
      else                    act = '1;
      chk($sformatf("%s[%0d]", nm, idx), act, exp);
   endtask

   task automatic clear_src();
      for (int c = 0; c < CH; c++) begin
         pk_len[c].delete();
         pk_seq[c].delete();
         beat_i[c]   = 0;
         bub[c]      = -1;
         seq_next[c] = 0;
         acc_cnt[c]  = 0;
      end
      hs_v = '0;
      acc_cyc.delete();
      out_q.delete();
   endtask

   task automatic load(input int ch, input int len);
      pk_len[ch].push_back(len);
      pk_seq[ch].push_back(seq_next[ch]);
      seq_next[ch]++;
   endtask

   task automatic drive();
      logic v;
      rst = rst_want;
      bus.m_axis_rsp_tready = tready_want;
      for (int c = 0; c < CH; c++) begin
         v = 1'b0;
         bus.s_axis_rsp_last[c] = 1'b0;
         if (pk_len[c].size() > 0) begin
            if (bub[c] == beat_i[c]) bub[c] = -1;
            else                     v = 1'b1;
            bus.s_axis_rsp_data[c*PIO_DATA_W +: PIO_DATA_W] = mk_data(c, pk_seq[c][0], beat_i[c]);
            bus.s_axis_rsp_head[c*PIO_HEAD_W +: PIO_HEAD_W] = mk_head(c, pk_seq[c][0]);
            bus.s_axis_rsp_last[c] = (beat_i[c] == pk_len[c][0] - 1);
         end
         bus.s_axis_rsp_valid[c] = v;
      end
   endtask

   // Sources advance just after the edge on handshakes seen at the previous falling edge.
   task automatic cycle();
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) begin
         if (hs_v[c]) begin
            beat_i[c]++;
            if (beat_i[c] == pk_len[c][0]) begin
               void'(pk_len[c].pop_front());
               void'(pk_seq[c].pop_front());
               beat_i[c] = 0;
            end
         end
      end
      drive();
      @(negedge clk);
      cyc++;
      hs_v = bus.s_axis_rsp_valid & bus.s_axis_rsp_ready;
      for (int c = 0; c < CH; c++) begin
         if (hs_v[c]) begin
            acc_cnt[c]++;
            acc_cyc.push_back(cyc);
         end
      end
      if (bus.m_axis_rsp_tvalid && bus.m_axis_rsp_tready)
         out_q.push_back('{bus.m_axis_rsp_tdata, bus.m_axis_rsp_thead, bus.m_axis_rsp_tlast, cyc});
      if (dut.rr_ptr_q >= 3'd6) rr_bad++;
   endtask

   task automatic do_reset();
      clear_src();
      rst_want = 1'b1;
      cycle();
      cycle();
      rst_want = 1'b0;
      cycle();
   endtask

   task automatic run_until(input int n, input int budget, input string nm);
      int k;
      k = 0;
      while (out_q.size() < n && k < budget) begin
         cycle();
         k++;
      end
      repeat (3) cycle();
      chk(nm, out_q.size(), n);
   endtask

   initial begin
      int r4;
      int k;
      logic done1;
      rst_want    = 1'b1;
      tready_want = 1'b1;
      clear_src();
      drive();

      vt[0] = '{6'b101001, 3, 24'h000530, 3'd0};
      vt[1] = '{6'b100001, 2, 24'h000050, 3'd0};
      vt[2] = '{6'b010110, 3, 24'h000421, 3'd5};
      vt[3] = '{6'b001001, 2, 24'h000030, 3'd4};
      vt[4] = '{6'b111111, 6, 24'h321054, 3'd4};
      vt[5] = '{6'b000100, 1, 24'h000002, 3'd3};
      vt[6] = '{6'b100010, 2, 24'h000015, 3'd2};

      do_reset();
      chk("rst_tvalid", bus.m_axis_rsp_tvalid, 1'b0);
      chk("rst_sready", bus.s_axis_rsp_ready, '0);
      chk("rst_cnt", rsp_pkt_cnt, 32'd0);
      chk("rst_state", dut.state_q, IDLE);
      chk("rst_rr", dut.rr_ptr_q, 3'd0);

      // single channel, back-to-back 1-beat packets
      for (int i = 0; i < 3; i++) load(2, 1);
      run_until(3, 30, "a_count");
      for (int i = 0; i < 3; i++) begin
         chk_beat("a_beat", i, 2, i, 0, 1'b1);
         chk($sformatf("a_lat[%0d]", i),
             (i < out_q.size() && i < acc_cyc.size()) ? out_q[i].cyc - acc_cyc[i] : -1, 1);
         chk($sformatf("a_contig[%0d]", i),
             (i < out_q.size()) ? out_q[i].cyc - out_q[0].cyc : -1, i);
      end
      chk("a_cnt", rsp_pkt_cnt, 32'd3);

      do_reset();
      for (int r = 0; r < 7; r++) begin
         clear_src();
         for (int c = 0; c < CH; c++)
            if (vt[r].pend[c]) load(c, 1);
         run_until(vt[r].n, 40, $sformatf("tbl%0d_count", r));
         for (int i = 0; i < vt[r].n; i++)
            chk_beat($sformatf("tbl%0d_beat", r), i, int'(vt[r].order[4*i +: 4]), 0, 0, 1'b1);
         chk($sformatf("tbl%0d_rr", r), dut.rr_ptr_q, vt[r].rr_after);
      end
      chk("tbl_cnt", rsp_pkt_cnt, 32'd19);

      // packet lock across a source bubble
      do_reset();
      load(1, 4);
      bub[1] = 2;
      load(4, 2);
      r4    = 0;
      done1 = 1'b0;
      k     = 0;
      while (out_q.size() < 6 && k < 60) begin
         cycle();
         if (!done1 && bus.s_axis_rsp_ready[4]) r4++;
         if (hs_v[1] && bus.s_axis_rsp_last[1]) done1 = 1'b1;
         k++;
      end
      chk("b_ready4_early", r4, 0);
      chk("b_ch1_done", done1, 1'b1);
      run_until(6, 10, "b_count");
      for (int i = 0; i < 4; i++) chk_beat("b_ch1", i, 1, 0, i, i == 3);
      chk_beat("b_ch4", 4, 4, 0, 0, 1'b0);
      chk_beat("b_ch4", 5, 4, 0, 1, 1'b1);

      // back-pressure fills the skid then stalls the source
      do_reset();
      tready_want = 1'b0;
      load(0, 6);
      cycle();
      cycle();
      chk("c_hold_early", bus.m_axis_rsp_tdata, mk_data(0, 0, 0));
      repeat (3) cycle();
      chk("c_acc", acc_cnt[0], 2);
      chk("c_ready0", bus.s_axis_rsp_ready[0], 1'b0);
      chk("c_tvalid", bus.m_axis_rsp_tvalid, 1'b1);
      chk("c_hold_late", bus.m_axis_rsp_tdata, mk_data(0, 0, 0));
      chk("c_no_out", out_q.size(), 0);
      tready_want = 1'b1;
      run_until(6, 40, "c_count");
      for (int i = 0; i < 6; i++) chk_beat("c_beat", i, 0, 0, i, i == 5);

      // rr_ptr wrap 5 -> 0
      do_reset();
      load(4, 1);
      run_until(1, 20, "d_pre_count");
      chk_beat("d_pre", 0, 4, 0, 0, 1'b1);
      chk("d_rr5", dut.rr_ptr_q, 3'd5);
      out_q.delete();
      rr_bad = 0;
      for (int i = 0; i < 3; i++) begin
         load(5, 1);
         load(0, 1);
      end
      run_until(6, 40, "d_count");
      for (int i = 0; i < 6; i++) chk_beat("d_alt", i, (i % 2 == 0) ? 5 : 0, i / 2, 0, 1'b1);
      chk("d_rr_range", rr_bad, 0);
      chk("d_rr_end", dut.rr_ptr_q, 3'd1);
      chk("d_cnt", rsp_pkt_cnt, 32'd7);

      // reset in the middle of a packet
      load(3, 4);
      k = 0;
      while (acc_cnt[3] < 2 && k < 20) begin
         cycle();
         k++;
      end
      chk("e_acc", acc_cnt[3], 2);
      clear_src();
      rst_want = 1'b1;
      cycle();
      rst_want = 1'b0;
      cycle();
      chk("e_tvalid", bus.m_axis_rsp_tvalid, 1'b0);
      chk("e_state", dut.state_q, IDLE);
      chk("e_cnt", rsp_pkt_cnt, 32'd0);
      out_q.delete();
      load(2, 2);
      run_until(2, 20, "e_count");
      chk_beat("e_beat", 0, 2, 0, 0, 1'b0);
      chk_beat("e_beat", 1, 2, 0, 1, 1'b1);
      chk("e_cnt_after", rsp_pkt_cnt, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
